// File: rtl/genius_pkg.sv
// genius_pkg: shared definitions for the sequence player.
// Holds the FSM state encoding, the one-hot colour constants used by the
// sequence ROM, buttons and LEDs, and a small colour type.
package genius_pkg;

  typedef logic [3:0] colour_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GAP     = 3'd1,
    ST_SHOW    = 3'd2,
    ST_WAIT_IN = 3'd3,
    ST_WIN     = 3'd4,
    ST_LOSE    = 3'd5
  } state_t;

  localparam colour_t COL_G  = 4'b0001;
  localparam colour_t COL_R  = 4'b0010;
  localparam colour_t COL_Y  = 4'b0100;
  localparam colour_t COL_B  = 4'b1000;
  localparam colour_t ALL_ON = 4'b1111;

endpackage

// File: rtl/genius_seq_player_if.sv
// genius_seq_player_if: bus between the player and the sequence ROM.
//   seq_addr  ROM address, driven by the player (master)
//   seq_data  one-hot colour, driven combinationally by the ROM (slave)
interface genius_seq_player_if;
  import genius_pkg::*;

  logic [3:0] seq_addr;
  colour_t    seq_data;

  modport master (output seq_addr, input seq_data);
  modport slave  (input seq_addr, output seq_data);

endinterface

// File: rtl/genius_press_detect.sv
// genius_press_detect: turns the debounced button vector into press events.
//   clk, rst   clock and synchronous active-high reset
//   buttons    debounced, synchronised buttons, active-high
//   press      high for the one cycle where buttons leave the all-released state
//   press_val  the button vector belonging to that press
// A press is only recognised after every button was released, so a button
// held across a state change never counts as a new press.
module genius_press_detect
  import genius_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  colour_t buttons,
  output logic    press,
  output colour_t press_val
);

  colour_t prev_buttons;

  // Remember last cycle's buttons to find the released-to-pressed edge.
  always_ff @(posedge clk) begin
    if (rst) prev_buttons <= '0;
    else     prev_buttons <= buttons;
  end

  assign press     = (buttons != '0) && (prev_buttons == '0);
  assign press_val = buttons;

endmodule

// File: rtl/genius_seq_player.sv
// genius_seq_player: plays a growing colour sequence from the sequence ROM
// and checks the player's presses against it.
//   clk, rst   clock and synchronous active-high reset
//   start      one-cycle start/restart pulse (honoured in IDLE/WIN/LOSE)
//   rom        ROM bus: registered seq_addr out, one-hot seq_data in
//   buttons    debounced player buttons, active-high
//   leds       colour lamps (playback colour, button echo, or all on in WIN)
//   round      current round 1..MAX_ROUND, 0 in IDLE
//   busy       high while a game is in progress
//   win, lose  game outcome levels
module genius_seq_player
  import genius_pkg::*;
#(
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int MAX_ROUND      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  genius_seq_player_if.master        rom,
  input  colour_t                    buttons,
  output colour_t                    leds,
  output logic [4:0]                 round,
  output logic                       busy,
  output logic                       win,
  output logic                       lose
);

  localparam int MAX_A   = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    ROUND_MAX = 5'(MAX_ROUND);

  state_t        state_q, state_n;
  logic [3:0]    addr_q, addr_n;
  logic [4:0]    round_q, round_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          shown_q, shown_n;
  logic          press;
  colour_t       press_val;
  logic          last_idx;

  genius_press_detect u_press (
    .clk       (clk),
    .rst       (rst),
    .buttons   (buttons),
    .press     (press),
    .press_val (press_val)
  );

  // shown_q marks that the final colour of this round has been played, so the
  // gap that follows leads to WAIT_IN rather than another SHOW. Without it the
  // leading gap of round 1 (addr 0 == round-1) would look identical.
  assign last_idx = ({1'b0, addr_q} == (round_q - 5'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      round_q <= '0;
      timer_q <= '0;
      shown_q <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      round_q <= round_n;
      timer_q <= timer_n;
      shown_q <= shown_n;
    end
  end

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    round_n = round_q;
    timer_n = timer_q;
    shown_n = shown_q;
    leds    = '0;

    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (state_q == ST_WIN) leds = ALL_ON;
        if (start) begin
          round_n = 5'd1;
          addr_n  = '0;
          timer_n = '0;
          shown_n = 1'b0;
          state_n = ST_GAP;
        end
      end

      ST_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_n = '0;
          if (shown_q) begin
            addr_n  = '0;
            shown_n = 1'b0;
            state_n = ST_WAIT_IN;
          end else begin
            state_n = ST_SHOW;
          end
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end

      ST_SHOW: begin
        leds = rom.seq_data;
        if (timer_q == SHOW_LAST) begin
          timer_n = '0;
          state_n = ST_GAP;
          if (last_idx) shown_n = 1'b1;
          else          addr_n  = addr_q + 4'd1;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end

      ST_WAIT_IN: begin
        leds = buttons;
        // A press takes priority over a timeout on the same cycle.
        if (press) begin
          if (press_val == rom.seq_data) begin
            if (!last_idx) begin
              addr_n  = addr_q + 4'd1;
              timer_n = '0;
            end else if (round_q == ROUND_MAX) begin
              state_n = ST_WIN;
            end else begin
              round_n = round_q + 5'd1;
              addr_n  = '0;
              timer_n = '0;
              shown_n = 1'b0;
              state_n = ST_GAP;
            end
          end else begin
            state_n = ST_LOSE;
          end
        end else if (timer_q == TO_LAST) begin
          state_n = ST_LOSE;
        end else begin
          timer_n = timer_q + 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign rom.seq_addr = addr_q;
  assign round        = round_q;
  assign busy         = (state_q == ST_GAP) || (state_q == ST_SHOW) || (state_q == ST_WAIT_IN);
  assign win          = (state_q == ST_WIN);
  assign lose         = (state_q == ST_LOSE);

endmodule

// File: tb/tb_genius_seq_player.sv
// tb_genius_seq_player: directed bench for genius_seq_player with short timing
// (SHOW=4, GAP=2, TIMEOUT=20, MAX_ROUND=3) and a ROM that always returns green.
// Inputs change 1 time unit after a rising edge; outputs are read there too.
module tb_genius_seq_player;
  import genius_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  colour_t    buttons = '0;
  colour_t    leds;
  logic [4:0] round;
  logic       busy, win, lose;

  int n_pass  = 0;
  int n_total = 0;

  genius_seq_player_if rom_if ();
  assign rom_if.seq_data = COL_G;

  genius_seq_player #(
    .SHOW_CYCLES    (4),
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (20),
    .MAX_ROUND      (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rom     (rom_if.master),
    .buttons (buttons),
    .leds    (leds),
    .round   (round),
    .busy    (busy),
    .win     (win),
    .lose    (lose)
  );

  always #5 clk = ~clk;

  // Hand-derived LED/address trace for round 2 playback, one entry per edge
  // starting at the edge that accepted the round-1 press.
  logic [3:0] pat_leds [0:13] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                                  4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};
  logic [3:0] pat_addr [0:13] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                                  4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
  logic [3:0] pat_r1 [0:7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    buttons = '0;
    start   = 1'b0;
    rst     = 1'b1;
    tick(2);
    rst     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic apply_press(input colour_t v);
    buttons = v;
    tick(1);
    buttons = '0;
    tick(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (leds !== 4'h0) $display("[TB] FAIL reset_leds: got %b expected 0000", leds); else n_pass++;
    n_total++; if (round !== 5'd0) $display("[TB] FAIL reset_round: got %0d expected 0", round); else n_pass++;
    n_total++; if ({busy, win, lose} !== 3'b000) $display("[TB] FAIL reset_flags: got busy/win/lose=%b expected 000", {busy, win, lose}); else n_pass++;
    n_total++; if (rom_if.seq_addr !== 4'h0) $display("[TB] FAIL reset_addr: got %0d expected 0", rom_if.seq_addr); else n_pass++;
  endtask

  task automatic test_first_round();
    do_reset();
    pulse_start();
    n_total++; if (busy !== 1'b1) $display("[TB] FAIL start_busy: got %b expected 1", busy); else n_pass++;
    n_total++; if (round !== 5'd1) $display("[TB] FAIL start_round: got %0d expected 1", round); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (leds !== pat_r1[i]) $display("[TB] FAIL r1_play_%0d: got %b expected %b", i, leds, pat_r1[i]); else n_pass++;
      tick(1);
    end
    // Now in WAIT_IN: leds echo the buttons immediately.
    buttons = COL_G;
    #1;
    n_total++; if (leds !== COL_G) $display("[TB] FAIL wait_echo: got %b expected 0001", leds); else n_pass++;
    tick(1);
    buttons = '0;
    n_total++; if (round !== 5'd2) $display("[TB] FAIL r2_round: got %0d expected 2", round); else n_pass++;
    for (int i = 0; i < 14; i++) begin
      n_total++; if (leds !== pat_leds[i]) $display("[TB] FAIL r2_play_%0d: got %b expected %b", i, leds, pat_leds[i]); else n_pass++;
      n_total++; if (rom_if.seq_addr !== pat_addr[i]) $display("[TB] FAIL r2_addr_%0d: got %0d expected %0d", i, rom_if.seq_addr, pat_addr[i]); else n_pass++;
      tick(1);
    end
    n_total++; if (rom_if.seq_addr !== 4'h0) $display("[TB] FAIL r2_wait_addr: got %0d expected 0", rom_if.seq_addr); else n_pass++;
  endtask

  task automatic test_win();
    do_reset();
    pulse_start();
    tick(8);
    apply_press(COL_G);
    tick(13);
    apply_press(COL_G);
    n_total++; if (rom_if.seq_addr !== 4'h1) $display("[TB] FAIL r2_addr_step: got %0d expected 1", rom_if.seq_addr); else n_pass++;
    apply_press(COL_G);
    tick(19);
    apply_press(COL_G);
    apply_press(COL_G);
    n_total++; if (win !== 1'b0) $display("[TB] FAIL win_early: got %b expected 0", win); else n_pass++;
    apply_press(COL_G);
    n_total++; if (win !== 1'b1) $display("[TB] FAIL win_flag: got %b expected 1", win); else n_pass++;
    n_total++; if (leds !== ALL_ON) $display("[TB] FAIL win_leds: got %b expected 1111", leds); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("[TB] FAIL win_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (round !== 5'd3) $display("[TB] FAIL win_round: got %0d expected 3", round); else n_pass++;
    pulse_start();
    n_total++; if (round !== 5'd1) $display("[TB] FAIL restart_round: got %0d expected 1", round); else n_pass++;
    n_total++; if ({win, busy} !== 2'b01) $display("[TB] FAIL restart_flags: got win/busy=%b expected 01", {win, busy}); else n_pass++;
  endtask

  task automatic test_wrong_press();
    do_reset();
    pulse_start();
    tick(8);
    apply_press(COL_G);
    tick(13);
    apply_press(COL_G);
    buttons = COL_Y;
    tick(1);
    n_total++; if (lose !== 1'b1) $display("[TB] FAIL wrong_lose: got %b expected 1", lose); else n_pass++;
    n_total++; if (round !== 5'd2) $display("[TB] FAIL wrong_round: got %0d expected 2", round); else n_pass++;
    n_total++; if (leds !== 4'h0) $display("[TB] FAIL wrong_leds: got %b expected 0000", leds); else n_pass++;
    buttons = '0;
  endtask

  task automatic test_multi_button();
    do_reset();
    pulse_start();
    tick(8);
    buttons = COL_G | COL_R;
    tick(1);
    buttons = '0;
    n_total++; if (lose !== 1'b1) $display("[TB] FAIL multi_lose: got %b expected 1", lose); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("[TB] FAIL multi_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_held_button();
    do_reset();
    pulse_start();
    buttons = COL_G;
    tick(11);
    n_total++; if (round !== 5'd1) $display("[TB] FAIL held_round: got %0d expected 1", round); else n_pass++;
    n_total++; if (leds !== COL_G) $display("[TB] FAIL held_echo: got %b expected 0001", leds); else n_pass++;
    n_total++; if (lose !== 1'b0) $display("[TB] FAIL held_lose: got %b expected 0", lose); else n_pass++;
    buttons = '0;
    tick(1);
    buttons = COL_G;
    tick(1);
    buttons = '0;
    n_total++; if (round !== 5'd2) $display("[TB] FAIL held_repress: got %0d expected 2", round); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    pulse_start();
    tick(27);
    n_total++; if (lose !== 1'b0) $display("[TB] FAIL timeout_early: got %b expected 0", lose); else n_pass++;
    tick(1);
    n_total++; if (lose !== 1'b1) $display("[TB] FAIL timeout_lose: got %b expected 1", lose); else n_pass++;
    n_total++; if (round !== 5'd1) $display("[TB] FAIL timeout_round: got %0d expected 1", round); else n_pass++;
    // Press on the final timeout cycle must win over the timeout.
    pulse_start();
    tick(27);
    buttons = COL_G;
    tick(1);
    buttons = '0;
    n_total++; if (lose !== 1'b0) $display("[TB] FAIL tie_lose: got %b expected 0", lose); else n_pass++;
    n_total++; if (round !== 5'd2) $display("[TB] FAIL tie_round: got %0d expected 2", round); else n_pass++;
  endtask

  task automatic test_reset_during_show();
    do_reset();
    pulse_start();
    tick(3);
    n_total++; if (leds !== COL_G) $display("[TB] FAIL midshow_leds: got %b expected 0001", leds); else n_pass++;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_total++; if (leds !== 4'h0) $display("[TB] FAIL abort_leds: got %b expected 0000", leds); else n_pass++;
    n_total++; if (round !== 5'd0) $display("[TB] FAIL abort_round: got %0d expected 0", round); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_win();
    test_wrong_press();
    test_multi_button();
    test_held_button();
    test_timeout();
    test_reset_during_show();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
